// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: fixed priority to A with
// starvation escalation for B, registered write stage and pending-write scoreboard.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [DATA_W-1:0]    a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [DATA_W-1:0]    b_data,
   output logic                 b_ready,
   input  logic                 sb_set,
   input  logic [ADDR_W-1:0]    sb_addr,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic [2**ADDR_W-1:0] pending,
   output logic                 grant_b
);

   localparam int         NREG  = 2**ADDR_W;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic              starve;
   logic              win_b;
   logic              accept;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic [3:0]        wait_cnt;
   logic [NREG-1:0]   pending_nxt;

   always_comb begin
      starve   = (wait_cnt == LIMIT);
      win_b    = b_valid && (starve || !a_valid);
      a_ready  = !rst && a_valid && !win_b;
      b_ready  = !rst && win_b;
      accept   = a_ready || b_ready;
      win_addr = b_ready ? b_addr : a_addr;
      win_data = b_ready ? b_data : a_data;
   end

   // Set is applied after clear so a newly issued producer survives a retiring write.
   always_comb begin
      pending_nxt = pending;
      if (rf_we)
         pending_nxt[rf_waddr] = 1'b0;
      if (sb_set && (sb_addr != '0))
         pending_nxt[sb_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         grant_b  <= 1'b0;
         pending  <= '0;
         wait_cnt <= '0;
      end else begin
         if (accept) begin
            // Writes to register 0 are consumed but never reach the register file.
            rf_we    <= (win_addr != '0);
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
            grant_b  <= b_ready && (win_addr != '0);
         end else begin
            rf_we   <= 1'b0;
            grant_b <= 1'b0;
         end

         if (b_valid && !b_ready) begin
            if (wait_cnt != LIMIT)
               wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= '0;
         end

         pending <= pending_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0, sb_set = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0, sb_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, rf_we, grant_b;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_denied = 0;
   bit [31:0]   m_pend = '0;
   bit          m_we = 1'b0;
   bit          m_gb = 1'b0;
   bit [4:0]    m_waddr = '0;
   bit [31:0]   m_wdata = '0;

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .sb_set(sb_set), .sb_addr(sb_addr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pending(pending), .grant_b(grant_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit r, input bit av, input int aa, input logic [31:0] ad,
                        input bit bv, input int ba, input logic [31:0] bd,
                        input bit ss, input int sa);
      rst = r; a_valid = av; a_addr = 5'(aa); a_data = ad;
      b_valid = bv; b_addr = 5'(ba); b_data = bd;
      sb_set = ss; sb_addr = 5'(sa);
   endtask

   // One clock: check grants before the edge, then advance the model and check outputs.
   task automatic tick();
      bit exp_b, exp_a;
      bit [4:0] w_addr;
      exp_b = !rst && b_valid && (m_denied >= LIMIT || !a_valid);
      exp_a = !rst && a_valid && !exp_b;
      @(negedge clk);
      chk("a_ready", 32'(a_ready), 32'(exp_a));
      chk("b_ready", 32'(b_ready), 32'(exp_b));
      @(posedge clk);
      if (rst) begin
         m_denied = 0; m_pend = '0; m_we = 0; m_gb = 0; m_waddr = '0; m_wdata = '0;
      end else begin
         if (m_we) m_pend[m_waddr] = 1'b0;
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
         if (exp_a || exp_b) begin
            w_addr = exp_b ? b_addr : a_addr;
            m_we = (w_addr != 0);
            m_gb = exp_b;
            if (m_we) begin
               m_waddr = w_addr;
               m_wdata = exp_b ? b_data : a_data;
            end
         end else begin
            m_we = 0;
         end
         if (b_valid && !exp_b) m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
         else m_denied = 0;
      end
      #1;
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("pending", pending, m_pend);
      if (m_we) begin
         chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
         chk("rf_wdata", rf_wdata, m_wdata);
         chk("grant_b", 32'(grant_b), 32'(m_gb));
      end
   endtask

   initial begin
      // reset held two cycles with A requesting
      drive(1, 1, 3, 32'h1111, 0, 0, 0, 0, 0); tick(); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("rst_rf_we", 32'(rf_we), 32'h0);
      chk("rst_pending", pending, 32'h0);

      // single A write
      drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); tick();
      chk("single_addr", 32'(rf_waddr), 32'd5);
      chk("single_data", rf_wdata, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("single_we_off", 32'(rf_we), 32'h0);
      chk("single_hold", 32'(rf_waddr), 32'd5);

      // contention, B granted when A drops
      for (int i = 1; i <= 3; i++) begin
         drive(0, 1, i, 32'h100 + 32'(i), 1, 7, 32'h777, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 1, 7, 32'h777, 0, 0); tick();
      chk("contend_b_addr", 32'(rf_waddr), 32'd7);
      chk("contend_grant_b", 32'(grant_b), 32'h1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      // starvation escalation
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 16 + i, 32'h200 + 32'(i), 1, 9, 32'h999, 0, 0); tick();
         if (i == 4) begin
            chk("starve_b_addr", 32'(rf_waddr), 32'd9);
            b_valid = 0;
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      // register 0
      drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0); tick();
      chk("reg0_we", 32'(rf_we), 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("reg0_pending", pending, 32'h0);

      // scoreboard: set wins over simultaneous clear
      drive(0, 0, 0, 0, 0, 0, 0, 1, 12); tick();
      chk("sb_set12", 32'(pending[12]), 32'h1);
      drive(0, 0, 0, 0, 1, 12, 32'hC0C0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 12); tick();
      chk("sb_set_wins", 32'(pending[12]), 32'h1);
      drive(0, 1, 12, 32'h1212, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("sb_clear12", 32'(pending[12]), 32'h0);

      // mid-operation reset drops the pending write
      drive(0, 1, 6, 32'h66, 0, 0, 0, 1, 6); tick();
      drive(1, 1, 7, 32'h77, 1, 8, 32'h88, 1, 9); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("midrst_we", 32'(rf_we), 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
